// File: rtl/rf_wb_if.sv
// Writeback arbiter bus: two requester handshakes, RF write port, forwarded read ports.
interface rf_wb_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 5
);
  logic              req0_valid;
  logic              req0_ready;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req1_valid;
  logic              req1_ready;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              rf_rw;
  logic [ADDR_W-1:0] rf_wa;
  logic [DATA_W-1:0] rf_wd;
  logic [ADDR_W-1:0] ra0;
  logic [ADDR_W-1:0] ra1;
  logic [DATA_W-1:0] rf_rd0;
  logic [DATA_W-1:0] rf_rd1;
  logic [DATA_W-1:0] rd0;
  logic [DATA_W-1:0] rd1;
  logic              busy;

  // Environment side: requesters, read consumers and the register file itself.
  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    output ra0, ra1, rf_rd0, rf_rd1,
    input  req0_ready, req1_ready, rf_rw, rf_wa, rf_wd, rd0, rd1, busy
  );

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    input  ra0, ra1, rf_rd0, rf_rd1,
    output req0_ready, req1_ready, rf_rw, rf_wa, rf_wd, rd0, rd1, busy
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Two-requester writeback arbiter with 1-entry holding buffers, age/round-robin
// drain into the single RF write port, and forwarding of pending writes.
module rf_wb_arbiter #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 5
) (
  input  logic   clk,
  input  logic   rst,
  rf_wb_if.slave bus
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  logic [1:0] full_q, full_d;
  wb_entry_t  ent_q [2];
  wb_entry_t  ent_d [2];
  logic       older_q, older_d;
  logic       last_grant_q, last_grant_d;

  logic [1:0] grant;
  logic [1:0] ready;
  logic [1:0] cap;
  logic [1:0] req_valid;
  wb_entry_t  req_ent [2];
  logic       sel;

  assign req_valid  = {bus.req1_valid, bus.req0_valid};
  assign req_ent[0] = '{addr: bus.req0_addr, data: bus.req0_data};
  assign req_ent[1] = '{addr: bus.req1_addr, data: bus.req1_data};

  // Grant, acceptance and write-port drive from registered buffer state.
  always_comb begin
    grant[0]   = full_q[0] & (~full_q[1] | ~older_q);
    grant[1]   = full_q[1] & (~full_q[0] | older_q);
    ready      = {~rst & (~full_q[1] | grant[1]), ~rst & (~full_q[0] | grant[0])};
    cap        = req_valid & ready;
    sel        = grant[1];
    bus.rf_rw  = (|grant) & ~rst;
    bus.rf_wa  = bus.rf_rw ? ent_q[sel].addr : '0;
    bus.rf_wd  = bus.rf_rw ? ent_q[sel].data : '0;
    bus.req0_ready = ready[0];
    bus.req1_ready = ready[1];
    bus.busy   = (|full_q) & ~rst;
  end

  // Forwarding: youngest matching buffer wins, i.e. the non-older one on a double hit.
  always_comb begin
    bus.rd0 = bus.rf_rd0;
    bus.rd1 = bus.rf_rd1;
    if (!rst) begin
      if (full_q[0] && full_q[1] && ent_q[0].addr == bus.ra0 && ent_q[1].addr == bus.ra0)
        bus.rd0 = older_q ? ent_q[0].data : ent_q[1].data;
      else if (full_q[0] && ent_q[0].addr == bus.ra0)
        bus.rd0 = ent_q[0].data;
      else if (full_q[1] && ent_q[1].addr == bus.ra0)
        bus.rd0 = ent_q[1].data;

      if (full_q[0] && full_q[1] && ent_q[0].addr == bus.ra1 && ent_q[1].addr == bus.ra1)
        bus.rd1 = older_q ? ent_q[0].data : ent_q[1].data;
      else if (full_q[0] && ent_q[0].addr == bus.ra1)
        bus.rd1 = ent_q[0].data;
      else if (full_q[1] && ent_q[1].addr == bus.ra1)
        bus.rd1 = ent_q[1].data;
    end
  end

  // Next state: drain granted buffer, capture accepted requests, track age and RR pointer.
  always_comb begin
    full_d       = full_q;
    ent_d        = ent_q;
    older_d      = older_q;
    last_grant_d = last_grant_q;

    for (int i = 0; i < 2; i++) begin
      if (grant[i]) full_d[i] = 1'b0;
      if (cap[i]) begin
        full_d[i] = 1'b1;
        ent_d[i]  = req_ent[i];
      end
    end

    if (cap[0] && cap[1])
      older_d = ~last_grant_q;
    else if (cap[0] && full_q[1] && !grant[1])
      older_d = 1'b1;
    else if (cap[1] && full_q[0] && !grant[0])
      older_d = 1'b0;

    if (|grant) last_grant_d = grant[1];

    if (rst) begin
      full_d       = 2'b00;
      older_d      = 1'b0;
      last_grant_d = 1'b1;
    end
  end

  // State registers; synchronous reset is folded into the _d logic above.
  always_ff @(posedge clk) begin
    full_q       <= full_d;
    ent_q        <= ent_d;
    older_q      <= older_d;
    last_grant_q <= last_grant_d;
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: expected RF writes go into a scoreboard
// queue at stimulus time; a negedge monitor pops and compares on every rf_rw.
module tb_rf_wb_arbiter;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned ADDR_W = 5;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  logic rf_init;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   wr_cnt   = 0;
  wr_t  exp_q[$];
  logic [DATA_W-1:0] rf_mem [32];

  rf_wb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  rf_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Register file model: clears only on rf_init so mid-flight reset keeps contents.
  always @(posedge clk) begin
    if (rf_init) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= '0;
    end else if (bus.rf_rw) begin
      rf_mem[bus.rf_wa] <= bus.rf_wd;
    end
  end
  assign bus.rf_rd0 = rf_mem[bus.ra0];
  assign bus.rf_rd1 = rf_mem[bus.ra1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every RF write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (bus.rf_rw === 1'b1) begin
      wr_t got;
      wr_t e;
      wr_cnt++;
      got = '{addr: bus.rf_wa, data: bus.rf_wd};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d data %h expected no write", got.addr, got.data);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          n_fail++;
          $display("FAIL rf_write: got addr %0d data %h expected addr %0d data %h",
                   got.addr, got.data, e.addr, e.data);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    exp_q.push_back('{addr: a, data: d});
  endtask

  task automatic drive0(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.req0_valid = v; bus.req0_addr = a; bus.req0_data = d;
  endtask

  task automatic drive1(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.req1_valid = v; bus.req1_addr = a; bus.req1_data = d;
  endtask

  initial begin
    int k0;
    int k1;
    int wr_base;
    logic a0;
    logic a1;

    rst = 1'b1;
    rf_init = 1'b1;
    drive0(1'b1, 5'd0, 64'h0);
    drive1(1'b0, 5'd0, 64'h0);
    bus.ra0 = '0;
    bus.ra1 = '0;

    // Reset held 3 cycles with a pending request.
    repeat (3) begin
      @(negedge clk);
      check("rst_ready0", 64'(bus.req0_ready), 64'd0);
      check("rst_rf_rw",  64'(bus.rf_rw), 64'd0);
      check("rst_busy",   64'(bus.busy), 64'd0);
      cyc();
    end
    rst = 1'b0;
    rf_init = 1'b0;
    drive0(1'b0, 5'd0, 64'h0);
    repeat (2) begin
      @(negedge clk);
      check("idle_busy", 64'(bus.busy), 64'd0);
      cyc();
    end

    // Single write with forwarding before commit.
    drive0(1'b1, 5'd5, 64'h1234);
    push(5'd5, 64'h1234);
    @(negedge clk);
    check("single_ready0", 64'(bus.req0_ready), 64'd1);
    cyc();
    drive0(1'b0, 5'd0, 64'h0);
    bus.ra0 = 5'd5;
    @(negedge clk);
    check("single_fwd_rd0", bus.rd0, 64'h1234);
    check("single_busy", 64'(bus.busy), 64'd1);
    cyc();
    @(negedge clk);
    check("single_commit_rd0", bus.rd0, 64'h1234);
    check("single_idle_busy", 64'(bus.busy), 64'd0);
    cyc();

    // Tie just after reset: req0 first.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    drive0(1'b1, 5'd3, 64'hA);
    drive1(1'b1, 5'd4, 64'hB);
    push(5'd3, 64'hA);
    push(5'd4, 64'hB);
    @(negedge clk);
    check("tie_ready0", 64'(bus.req0_ready), 64'd1);
    check("tie_ready1", 64'(bus.req1_ready), 64'd1);
    cyc();
    drive0(1'b0, 5'd0, 64'h0);
    drive1(1'b0, 5'd0, 64'h0);
    repeat (3) cyc();

    // Lone req0 write moves the RR pointer to 0, so the next tie goes to req1.
    drive0(1'b1, 5'd10, 64'hE);
    push(5'd10, 64'hE);
    cyc();
    drive0(1'b0, 5'd0, 64'h0);
    repeat (2) cyc();
    drive0(1'b1, 5'd11, 64'hF0);
    drive1(1'b1, 5'd12, 64'hF1);
    push(5'd12, 64'hF1);
    push(5'd11, 64'hF0);
    cyc();
    drive0(1'b0, 5'd0, 64'h0);
    drive1(1'b0, 5'd0, 64'h0);
    repeat (3) cyc();

    // Ordering on addr 7: req1 then req0.
    drive1(1'b1, 5'd7, 64'h22);
    push(5'd7, 64'h22);
    bus.ra1 = 5'd7;
    @(negedge clk);
    check("ord_ready1", 64'(bus.req1_ready), 64'd1);
    cyc();
    drive1(1'b0, 5'd0, 64'h0);
    drive0(1'b1, 5'd7, 64'h11);
    push(5'd7, 64'h11);
    @(negedge clk);
    check("ord_fwd_rd1_t1", bus.rd1, 64'h22);
    check("ord_ready0", 64'(bus.req0_ready), 64'd1);
    cyc();
    drive0(1'b0, 5'd0, 64'h0);
    @(negedge clk);
    check("ord_fwd_rd1_t2", bus.rd1, 64'h11);
    cyc();
    @(negedge clk);
    check("ord_rd1_t3", bus.rd1, 64'h11);
    check("ord_rf7", rf_mem[7], 64'h11);
    cyc();

    // Same-address tie with RR pointer 0: req1 older; double-hit forwarding.
    drive0(1'b1, 5'd20, 64'h31);
    drive1(1'b1, 5'd20, 64'h32);
    push(5'd20, 64'h32);
    push(5'd20, 64'h31);
    push(5'd20, 64'h33);
    bus.ra0 = 5'd20;
    cyc();
    drive0(1'b0, 5'd0, 64'h0);
    drive1(1'b1, 5'd20, 64'h33);
    @(negedge clk);
    check("sa_ready1", 64'(bus.req1_ready), 64'd1);
    check("sa_ready0", 64'(bus.req0_ready), 64'd0);
    check("sa_rd0_t1", bus.rd0, 64'h31);
    cyc();
    drive1(1'b0, 5'd0, 64'h0);
    @(negedge clk);
    check("sa_rd0_t2", bus.rd0, 64'h33);
    cyc();
    @(negedge clk);
    check("sa_rd0_t3", bus.rd0, 64'h33);
    cyc();
    @(negedge clk);
    check("sa_rd0_t4", bus.rd0, 64'h33);
    check("sa_busy", 64'(bus.busy), 64'd0);
    cyc();

    // Streaming from reset: 10 writes per requester, alternating req0/req1.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      push(5'(k), 64'h100 + 64'(k));
      push(5'(22 + k), 64'h200 + 64'(k));
    end
    k0 = 0;
    k1 = 0;
    wr_base = wr_cnt;
    for (int c = 0; c < 40; c++) begin
      drive0(k0 < 10, 5'(k0), 64'h100 + 64'(k0));
      drive1(k1 < 10, 5'(22 + k1), 64'h200 + 64'(k1));
      @(negedge clk);
      if (c >= 1 && c <= 20) check("stream_rf_rw", 64'(bus.rf_rw), 64'd1);
      a0 = bus.req0_valid & bus.req0_ready;
      a1 = bus.req1_valid & bus.req1_ready;
      cyc();
      if (a0) k0++;
      if (a1) k1++;
      if (k0 == 10 && k1 == 10 && c >= 21) break;
    end
    drive0(1'b0, 5'd0, 64'h0);
    drive1(1'b0, 5'd0, 64'h0);
    check("stream_k0", 64'(k0), 64'd10);
    check("stream_k1", 64'(k1), 64'd10);
    check("stream_writes", 64'(wr_cnt - wr_base), 64'd20);
    cyc();

    // Reset mid-flight: both buffers full, pending writes dropped.
    drive0(1'b1, 5'd1, 64'h55);
    drive1(1'b1, 5'd2, 64'h66);
    bus.ra0 = 5'd1;
    bus.ra1 = 5'd2;
    cyc();
    drive0(1'b0, 5'd0, 64'h0);
    drive1(1'b0, 5'd0, 64'h0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_rf_rw", 64'(bus.rf_rw), 64'd0);
    check("mid_rst_busy",  64'(bus.busy), 64'd0);
    check("mid_rst_rd0",   bus.rd0, 64'h101);
    check("mid_rst_rd1",   bus.rd1, 64'h102);
    check("mid_rst_ready1", 64'(bus.req1_ready), 64'd0);
    cyc();
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("post_rst_busy", 64'(bus.busy), 64'd0);
      check("post_rst_rd0", bus.rd0, 64'h101);
      cyc();
    end

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
